// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serializer.
// Frames leave back-to-back with no idle gap while the FIFO still holds data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [7:0]               i_wr_byte,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [FIFO_DEPTH_LOG2:0] o_count,
  output logic                     o_overflow,
  output logic                     o_tx,
  output logic                     o_tx_busy,
  output logic                     o_tx_done,
  output logic [1:0]               o_dbg_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]              LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Handshake: a write is accepted on any rising edge where i_wr_en is high and the
  // registered o_full is low; otherwise it is dropped and o_overflow pulses next cycle.

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count_n;
  logic                       wr_acc, pop;

  tx_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n, busy_n, done_n;

  assign wr_acc      = i_wr_en && !o_full;
  assign o_dbg_state = state;

  always_comb begin
    count_n = o_count;
    case ({wr_acc, pop})
      2'b10:   count_n = o_count + 1'b1;
      2'b01:   count_n = o_count - 1'b1;
      default: count_n = o_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_wr_byte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      o_count    <= count_n;
      o_empty    <= (count_n == '0);
      o_full     <= (count_n == FULL_CNT);
      o_overflow <= i_wr_en && o_full;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      o_tx      <= tx_n;
      o_tx_busy <= busy_n;
      o_tx_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!o_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!o_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[idx_n];
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (cnt_n == LAST_CNT);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo; a cycle-level frame model of the
// FIFO and line predicts every output, checked each cycle on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int CPB   = 8;
  localparam int DLOG  = 4;
  localparam int DEPTH = 1 << DLOG;
  localparam int FRAME = 10 * CPB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_byte = 8'h00;
  logic            full, empty, overflow, tx, tx_busy, tx_done;
  logic [DLOG:0]   count;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DLOG)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_byte(wr_byte),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
    .o_tx(tx), .o_tx_busy(tx_busy), .o_tx_done(tx_done), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the bytes the FIFO should contain; a frame occupies FRAME cycles
  // starting the cycle after the edge that popped it, and the next pop waits for it.
  logic [7:0] exp_q[$];
  logic [7:0] frame_byte = 8'h00;
  int         frame_start = 0;
  bit         in_frame = 0;
  int         cyc = 0;
  bit         exp_ovf = 0;
  bit         m_full_pre, m_line_free, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      in_frame = 0;
      exp_ovf  = 0;
    end else begin
      cyc++;
      m_full_pre  = (exp_q.size() == DEPTH);
      m_line_free = !in_frame || (cyc - frame_start >= FRAME);
      m_pop       = m_line_free && (exp_q.size() != 0);
      if (m_line_free) in_frame = 0;
      exp_ovf = wr_en && m_full_pre;
      if (m_pop) begin
        frame_byte  = exp_q.pop_front();
        frame_start = cyc;
        in_frame    = 1;
      end
      if (wr_en && !m_full_pre) exp_q.push_back(wr_byte);
    end
  end

  function automatic logic line_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  int done_seen = 0;
  int ovf_seen  = 0;

  always @(negedge clk) begin
    int k;
    logic exp_tx;
    k      = cyc - frame_start;
    exp_tx = in_frame ? line_bit(frame_byte, k) : 1'b1;
    check("tx_line",  tx,       exp_tx);
    check("tx_busy",  tx_busy,  in_frame);
    check("tx_done",  tx_done,  in_frame && (k == FRAME - 1));
    check("count",    count,    exp_q.size());
    check("empty",    empty,    exp_q.size() == 0);
    check("full",     full,     exp_q.size() == DEPTH);
    check("overflow", overflow, exp_ovf);
    done_seen += int'(tx_done);
    ovf_seen  += int'(overflow);
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_byte = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, o0, guard;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx",    tx,       1);
    check("rst_busy",  tx_busy,  0);
    check("rst_done",  tx_done,  0);
    check("rst_ovf",   overflow, 0);
    check("rst_count", count,    0);
    check("rst_empty", empty,    1);
    check("rst_full",  full,     0);

    // single byte: line falls one edge after the write edge
    d0 = done_seen;
    wr(8'hAB);
    check("single_pre_fall", tx, 1);
    idle(1);
    check("single_fall", tx, 0);
    idle(FRAME + 4);
    check("single_done_cnt", done_seen - d0, 1);
    check("single_idle_tx", tx, 1);

    // back-to-back
    d0 = done_seen;
    wr(8'h3F); wr(8'h00); wr(8'hFF);
    idle(3 * FRAME + 4);
    check("b2b_done_cnt", done_seen - d0, 3);
    check("b2b_empty", empty, 1);

    // overflow: 20 writes into a 16-deep FIFO with one byte drained early
    d0 = done_seen;
    o0 = ovf_seen;
    for (int i = 1; i <= 20; i++) begin
      wr(8'(i));
      if (i == 17) begin
        check("ovf_count16", count, 16);
        check("ovf_full", full, 1);
      end
    end
    idle(2);
    check("ovf_pulses", ovf_seen - o0, 3);
    idle(17 * FRAME + 10);
    check("ovf_frames", done_seen - d0, 17);
    check("ovf_end_empty", empty, 1);
    check("ovf_end_count", count, 0);

    // write landing on the same edge as the stop-bit pop
    wr(8'h11);
    wr(8'h22);
    idle(FRAME - 1);
    check("simul_pre_count", count, 1);
    check("simul_pre_done", tx_done, 1);
    wr(8'h55);
    check("simul_count", count, 1);
    check("simul_start", tx, 0);
    check("simul_busy", tx_busy, 1);
    idle(2 * FRAME + 4);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3 * FRAME));
      else repeat ($urandom_range(1, 6)) wr(8'($urandom_range(0, 255)));
    end
    guard = 0;
    while ((exp_q.size() != 0 || in_frame) && guard < 40 * FRAME) begin
      idle(1);
      guard++;
    end
    check("rand_drain_timeout", guard < 40 * FRAME, 1);
    check("rand_drain_empty", empty, 1);

    // reset during data bit 3 of 0xAB with 4 bytes waiting
    wr(8'hAB); wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    idle(4 * CPB);
    check("mid_count", count, 4);
    check("mid_busy", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    d0 = done_seen;
    idle(3 * FRAME);
    check("post_rst_quiet", done_seen - d0, 0);
    check("post_rst_tx", tx, 1);
    wr(8'hC3);
    idle(FRAME + 4);
    check("post_rst_frame", done_seen - d0, 1);
    check("post_rst_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes from a parallel write port into an internal FIFO and serializes them onto an 8N1 line (1 start, 8 data LSB-first, 1 stop). It is the line-driving counterpart of `uart_rx` and shares its `CLKS_PER_BIT` convention, so the two can be looped back directly. Producers (command logic, debug dumpers) can burst up to FIFO depth without waiting on the line; frames are sent back-to-back with no idle gap.

## Interface
- `CLKS_PER_BIT`, 434: clocks per bit period; legal range ≥ 2.
- `FIFO_DEPTH_LOG2`, 4: FIFO depth = 2^FIFO_DEPTH_LOG2 entries (16).
- `i_clk`  in  1  system clock. One clock; all logic runs on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  write strobe; one byte per cycle while high.
- `i_wr_byte`  in  8  byte to enqueue, sampled when `i_wr_en` is high.
- `o_full`  out  1  FIFO holds 2^FIFO_DEPTH_LOG2 entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_count`  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.
- `o_overflow`  out  1  one-cycle pulse when a write is dropped.
- `o_tx`  out  1  serial line; idle high.
- `o_tx_busy`  out  1  high while a frame is on the line.
- `o_tx_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Reset values: `o_tx`=1, `o_tx_busy`=0, `o_tx_done`=0, `o_overflow`=0, `o_count`=0, `o_empty`=1, `o_full`=0. Pointers, bit index, and baud counter are cleared. Reset asserted mid-frame aborts the frame; `o_tx` returns high asynchronously. FIFO contents are discarded.
- FIFO write: `i_wr_en` && !`o_full` enqueues `i_wr_byte` at the tail. `i_wr_en` && `o_full` drops the byte, leaves state unchanged, and pulses `o_overflow`. The full check uses the registered `o_full`: a write in the same cycle as a pop while full is still dropped.
- Pointers are FIFO_DEPTH_LOG2 bits wide and wrap modulo depth. Occupancy changes per cycle:
  - +1 on write only;
  - −1 on pop only;
  - unchanged on simultaneous accepted write and pop.
- Serializer FSM states:
  - IDLE: `o_tx`=1, busy=0. If !`o_empty`: pop the head into the shift register, go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `o_tx`=shift[index] for CLKS_PER_BIT cycles each. Index 0..7, LSB first. After index 7, go to STOP.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles. On the last cycle, pulse `o_tx_done`. If !`o_empty`, pop and go directly to START (zero-gap back-to-back); otherwise go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits wide. Counts 0..CLKS_PER_BIT−1 and reloads to 0 on every bit boundary.
- `o_tx_busy` is high in START, DATA, and STOP.

## Timing
- All outputs are registered; `o_overflow` and `o_tx_done` are exactly one cycle wide.
- Write-to-line latency from an empty, idle block:
  - byte written at edge N;
  - IDLE sees non-empty and pops at edge N+1;
  - `o_tx` falls after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles measured from the `o_tx` falling edge. For back-to-back frames, the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `o_tx_done` is high during the final stop-bit cycle. `o_tx_busy` stays high across back-to-back frames.
- `o_count`/`o_empty`/`o_full` reflect the edge-updated occupancy; they are valid the cycle after the write or pop.

## Test plan
- Single byte: write 0xAB at cycle 0 (CLKS_PER_BIT=434). Required: `o_tx` falls at cycle 1; bit order is 1,1,0,1,0,1,0,1; each bit lasts 434 cycles; `o_tx_done` pulses once 4340 cycles after the fall; line then stays idle high.
- Loopback to `uart_rx`: write 0x3F. Required: `uart_rx` outputs 0x3F with `o_rx_byte_rdy` pulsed once.
- Back-to-back: write 0x3F, 0x00, 0xFF on consecutive cycles. Required:
  - three frames, zero idle cycles between them, total 13020 cycles;
  - `o_tx_busy` high throughout;
  - three `o_tx_done` pulses;
  - loopback receives the three bytes in order.
- Overflow: write bytes 1..20 on 20 consecutive cycles. Required:
  - bytes 1..17 accepted (byte 1 popped at cycle 1);
  - `o_count`=16 and `o_full`=1 after cycle 16;
  - `o_overflow` pulses on cycles 17, 18, 19;
  - exactly 17 frames emitted in order 1..17;
  - `o_empty`=1 and `o_count`=0 at the end.
- Simultaneous write/pop: with FIFO holding 1 entry in STOP's last cycle, write 0x55. Required: pop and write occur in the same cycle, `o_count` stays 1, and the next frame starts with zero gap.
- Reset mid-frame: assert `i_rst` during DATA bit 3 of 0xAB with 4 bytes queued. Required:
  - `o_tx`=1 immediately;
  - busy=0, count=0, empty=1;
  - after release, no frame is sent until a new write;
  - a new write of 0xC3 transmits correctly.
